// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control path: memory-wait FSM
// states, default timeout and the pipeline write-enable vector layout.
package core_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam int TIMEOUT_DEFAULT = 64;

  localparam int PC     = 0;
  localparam int IF_ID  = 1;
  localparam int ID_EX  = 2;
  localparam int EX_MEM = 3;
  localparam int MEM_WB = 4;
  localparam int NUM_EN = 5;

endpackage

// File: rtl/mem_wait_fsm.sv
// Variable-latency data-memory wait tracker: issues dmem_req, reports when the
// pipeline must freeze, and raises a sticky error when the memory never answers.
module mem_wait_fsm
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_op,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic mem_busy,
  output logic mem_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  mem_state_e state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_set;
  logic       req_raw;
  logic       busy_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (err_set) mem_err <= 1'b1;
    end
  end

  // The wait counter includes the first request cycle issued from IDLE, so a
  // timeout forces completion on the cycle after TIMEOUT frozen cycles.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_set    = 1'b0;
    req_raw    = 1'b0;
    busy_raw   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_raw = 1'b1;
          if (!dmem_ready) begin
            busy_raw   = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = 8'd1;
          end
        end
      end
      MEM_WAIT: begin
        req_raw = 1'b1;
        if (dmem_ready) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= TIMEOUT_CNT) begin
          err_set    = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          busy_raw   = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Gating with reset_n drops the request immediately while reset is held.
  assign dmem_req = req_raw & reset_n;
  assign mem_busy = busy_raw & reset_n;

endmodule

// File: rtl/pipeline_hold_ctrl.sv
// Pipeline stall/flush controller: resolves memory freeze, branch flush and
// load-use stall into register write enables, and counts stalled cycles.
module pipeline_hold_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld_use_stall,
  input  logic             branch_taken,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              mem_busy;
  logic [NUM_EN-1:0] en;

  mem_wait_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_wait_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_op    (mem_read | mem_write),
    .dmem_ready(dmem_ready),
    .dmem_req  (dmem_req),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  // A memory freeze outranks a branch: the branch stays in the frozen EX stage
  // and flushes on the release cycle.
  always_comb begin
    en           = '1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mem_busy) begin
      en = '0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ld_use_stall) begin
      en[PC]       = 1'b0;
      en[IF_ID]    = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign pc_we     = en[PC];
  assign if_id_we  = en[IF_ID];
  assign id_ex_we  = en[ID_EX];
  assign ex_mem_we = en[EX_MEM];
  assign mem_wb_we = en[MEM_WB];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (!en[PC] && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Directed bench for pipeline_hold_ctrl with TIMEOUT = 8; inputs change on the
// falling edge and outputs are compared 1 ns later.
module tb_pipeline_hold_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_use_stall, branch_taken, mem_read, mem_write, dmem_ready;
  logic        dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_bubble, mem_err;
  logic [31:0] stall_cnt;
  logic [4:0]  en_vec;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_hold_ctrl #(
    .TIMEOUT(8),
    .CNT_W  (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ld_use_stall(ld_use_stall),
    .branch_taken(branch_taken),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .dmem_ready  (dmem_ready),
    .dmem_req    (dmem_req),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .id_ex_we    (id_ex_we),
    .ex_mem_we   (ex_mem_we),
    .mem_wb_we   (mem_wb_we),
    .if_id_flush (if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  assign en_vec = {mem_wb_we, ex_mem_we, id_ex_we, if_id_we, pc_we};

  // A request outstanding without a MEM-stage op means the frozen instruction vanished.
  assert property (@(posedge clk) disable iff (!reset_n) dmem_req |-> (mem_read | mem_write))
    else $error("[TB] FAIL mem_op dropped during MEM_WAIT");

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic br, input logic rd,
                               input logic wr, input logic rdy);
    @(negedge clk);
    ld_use_stall = ld;
    branch_taken = br;
    mem_read     = rd;
    mem_write    = wr;
    dmem_ready   = rdy;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ld_use_stall = 1'b0; branch_taken = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; dmem_ready = 1'b0;
    #1;
    checkOutput("reset_dmem_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
    checkOutput("reset_mem_err", {31'b0, mem_err}, 32'd0);
    checkOutput("reset_en", {27'b0, en_vec}, 32'h1f);
    repeat (2) @(posedge clk);
    checkOutput("reset_hold_stall_cnt", stall_cnt, 32'd0);

    // Release reset while a load is pending: two-cycle access.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("post_reset_req", {31'b0, dmem_req}, 32'd1);
    checkOutput("post_reset_freeze", {27'b0, en_vec}, 32'h00);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("post_reset_release", {27'b0, en_vec}, 32'h1f);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post_reset_stall_cnt", stall_cnt, 32'd1);
    checkOutput("idle_req", {31'b0, dmem_req}, 32'd0);

    // Zero-wait load.
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("zw_req", {31'b0, dmem_req}, 32'd1);
    checkOutput("zw_en", {27'b0, en_vec}, 32'h1f);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zw_stall_cnt", stall_cnt, 32'd1);

    // Four-cycle store: three frozen cycles, release on the fourth.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput($sformatf("st4_freeze_c%0d", i), {27'b0, en_vec}, 32'h00);
      checkOutput($sformatf("st4_req_c%0d", i), {31'b0, dmem_req}, 32'd1);
    end
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("st4_release", {27'b0, en_vec}, 32'h1f);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("st4_stall_cnt", stall_cnt, 32'd4);

    // Load-use stall with no memory op.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ldu_en", {27'b0, en_vec}, 32'h1c);
    checkOutput("ldu_bubble", {31'b0, id_ex_bubble}, 32'd1);
    checkOutput("ldu_flush", {31'b0, if_id_flush}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ldu_stall_cnt", stall_cnt, 32'd5);
    checkOutput("ldu_after_en", {27'b0, en_vec}, 32'h1f);

    // Branch held across a three-cycle memory wait; flush wins over load-use on release.
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput($sformatf("br_freeze_c%0d", i), {27'b0, en_vec}, 32'h00);
      checkOutput($sformatf("br_noflush_c%0d", i), {30'b0, if_id_flush, id_ex_bubble}, 32'd0);
    end
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("br_release_en", {27'b0, en_vec}, 32'h1f);
    checkOutput("br_release_flush", {30'b0, if_id_flush, id_ex_bubble}, 32'd3);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("br_stall_cnt", stall_cnt, 32'd7);

    // Timeout: memory never answers; 8 frozen cycles then forced release.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput($sformatf("to_freeze_c%0d", i), {27'b0, en_vec}, 32'h00);
      checkOutput($sformatf("to_err_c%0d", i), {31'b0, mem_err}, 32'd0);
    end
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("to_forced_release", {27'b0, en_vec}, 32'h1f);
    checkOutput("to_release_req", {31'b0, dmem_req}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("to_err_set", {31'b0, mem_err}, 32'd1);
    checkOutput("to_stall_cnt", stall_cnt, 32'd15);
    checkOutput("to_idle_req", {31'b0, dmem_req}, 32'd0);

    // Error is sticky across later accesses; FSM still works normally.
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("sticky_zw_en", {27'b0, en_vec}, 32'h1f);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("sticky_w2_freeze", {27'b0, en_vec}, 32'h00);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("sticky_w2_release", {27'b0, en_vec}, 32'h1f);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("sticky_err", {31'b0, mem_err}, 32'd1);
    checkOutput("sticky_stall_cnt", stall_cnt, 32'd16);

    // Reset in the middle of a wait: request drops at once, error clears.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("midwait_freeze", {27'b0, en_vec}, 32'h00);
    applyStimulus(0, 0, 1, 0, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("midwait_reset_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("midwait_reset_err", {31'b0, mem_err}, 32'd0);
    checkOutput("midwait_reset_cnt", stall_cnt, 32'd0);
    checkOutput("midwait_reset_en", {27'b0, en_vec}, 32'h1f);
    @(negedge clk);
    mem_read = 1'b0;
    reset_n  = 1'b1;
    #1;
    checkOutput("after_reset_idle_req", {31'b0, dmem_req}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("late_ready_ignored", {27'b0, en_vec}, 32'h1f);
    checkOutput("late_ready_cnt", stall_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
